// File: rtl/alu_operand_sequencer_if.sv
// Operand bundle handshake between the entry sequencer (master) and the downstream ALU (slave).
interface alu_operand_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int OPW   = 3
);
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic [OPW-1:0]   op_out;
   logic             operands_valid;
   logic             ready_in;

   modport master (
      output a_out,
      output b_out,
      output op_out,
      output operands_valid,
      input  ready_in
   );

   modport slave (
      input  a_out,
      input  b_out,
      input  op_out,
      input  operands_valid,
      output ready_in
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Switch-entry front end of the 8-bit ALU: debounced buttons step an A -> B -> OP -> HOLD FSM.
// Optional feature macro SEQ_TIMEOUT_EN: idle abort while waiting in S_B / S_OP.
module alu_operand_sequencer #(
   parameter int WIDTH          = 8,
   parameter int OPW            = 3,
   parameter int DB_CYCLES      = 1000000,
   parameter int TIMEOUT_CYCLES = 2**27
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        sw_in,
   input  logic                    btn_next,
   input  logic                    btn_clear,
   alu_operand_sequencer_if.master bus,
   output logic [1:0]              state_out
);

   localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

   if (DB_CYCLES < 2) begin : g_bad_db
      $error("DB_CYCLES must be at least 2");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_to
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_OP   = 2'b10,
      S_HOLD = 2'b11
   } state_t;

   state_t           state;
   logic [1:0]       raw;
   logic [1:0]       pulse;
   logic             next_p;
   logic             clear_p;
   logic             timeout_hit;
   logic             abort;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [OPW-1:0]   op_q;
   logic             valid_q;

   assign raw = {btn_clear, btn_next};

   // Per button: two-flop synchronizer, stability counter, rising-edge detect on the stable value.
   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync_p0;
      logic            sync_p1;
      logic            stable;
      logic            stable_d;
      logic [DB_W-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
         end else begin
            sync_p0  <= raw[gi];
            sync_p1  <= sync_p0;
            stable_d <= stable;
            if (sync_p1 == stable) begin
               cnt <= '0;
            end else if (cnt == DB_MAX) begin
               stable <= sync_p1;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign pulse[gi] = stable & ~stable_d;
   end

   assign next_p  = pulse[0];
   assign clear_p = pulse[1];

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] idle_cnt;
   logic            waiting;

   assign waiting     = (state == S_B) || (state == S_OP);
   assign timeout_hit = waiting && (idle_cnt == TO_MAX);

   // Any pulse or leaving the waiting states restarts the idle count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (!waiting || next_p || clear_p || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign abort = clear_p | timeout_hit;

   // Entry FSM; a clear coinciding with a transfer lands in the same place as the transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else if (abort) begin
         state   <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            S_A: begin
               if (next_p) begin
                  a_q   <= sw_in;
                  state <= S_B;
               end
            end
            S_B: begin
               if (next_p) begin
                  b_q   <= sw_in;
                  state <= S_OP;
               end
            end
            S_OP: begin
               if (next_p) begin
                  op_q    <= sw_in[OPW-1:0];
                  state   <= S_HOLD;
                  valid_q <= 1'b1;
               end
            end
            S_HOLD: begin
               if (bus.ready_in) begin
                  state   <= S_A;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state   <= S_A;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_out          = a_q;
   assign bus.b_out          = b_q;
   assign bus.op_out         = op_q;
   assign bus.operands_valid = valid_q;
   assign state_out          = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with short debounce and timeout settings.
module tb_alu_operand_sequencer;
   localparam int WIDTH = 8;
   localparam int OPW   = 3;
   localparam int DB    = 4;
   localparam int TO    = 50;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [OPW-1:0]   op;
   } bundle_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] sw_in = '0;
   logic             btn_next = 1'b0;
   logic             btn_clear = 1'b0;
   logic [1:0]       state_out;

   int      n_checks = 0;
   int      n_errors = 0;
   bundle_t sb_q[$];
   bit      seen_hold = 1'b0;

   alu_operand_sequencer_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

   alu_operand_sequencer #(
      .WIDTH(WIDTH), .OPW(OPW), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .sw_in(sw_in), .btn_next(btn_next),
      .btn_clear(btn_clear), .bus(bus), .state_out(state_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [WIDTH-1:0] v);
      sw_in    = v;
      btn_next = 1'b1;
      step(DB + 4);
      btn_next = 1'b0;
      step(DB + 4);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      step(1);
   endtask

   task automatic check_outputs(input string tag, input bundle_t e,
                                input logic v, input logic [1:0] s);
      check({tag, "_a"}, 32'(bus.a_out), 32'(e.a));
      check({tag, "_b"}, 32'(bus.b_out), 32'(e.b));
      check({tag, "_op"}, 32'(bus.op_out), 32'(e.op));
      check({tag, "_valid"}, 32'(bus.operands_valid), 32'(v));
      check({tag, "_state"}, 32'(state_out), 32'(s));
   endtask

   // Transfers are consumed against the scoreboard on the falling edge before the accepting edge.
   always @(negedge clk) begin
      if (state_out == 2'b11) seen_hold = 1'b1;
      if (bus.operands_valid && bus.ready_in) begin
         if (sb_q.size() == 0) begin
            check("xfer_unexpected", 32'(1), 32'(0));
         end else begin
            bundle_t e;
            e = sb_q.pop_front();
            check("xfer_a", 32'(bus.a_out), 32'(e.a));
            check("xfer_b", 32'(bus.b_out), 32'(e.b));
            check("xfer_op", 32'(bus.op_out), 32'(e.op));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bundle_t e;
      int lat;
      bus.ready_in = 1'b0;

      // Reset state
      #3;
      check_outputs("reset", '0, 1'b0, 2'b00);
      step(1);
      rst = 1'b0;
      step(1);

      // Async reset in the middle of entry
      press(8'h9C);
      check("midB_state", 32'(state_out), 32'(2'b01));
      check("midB_a", 32'(bus.a_out), 32'(8'h9C));
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_outputs("async_rst", '0, 1'b0, 2'b00);
      #1 rst = 1'b0;
      step(1);

      // Short glitch is rejected
      btn_next = 1'b1;
      step(3);
      btn_next = 1'b0;
      step(12);
      check("glitch_state", 32'(state_out), 32'(2'b00));

      // Bouncing input, then steady: one capture, fixed latency
      sw_in = 8'h47;
      for (int i = 0; i < 10; i++) begin
         btn_next = (i % 2 == 0);
         step(1);
      end
      check("bounce_state", 32'(state_out), 32'(2'b00));
      btn_next = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (lat == 0 && state_out == 2'b01) lat = i;
      end
      check("bounce_latency", 32'(lat), 32'(7));
      btn_next = 1'b0;
      sw_in = 8'hEE;
      step(DB + 6);
      check("bounce_once", 32'(state_out), 32'(2'b01));
      check("bounce_a", 32'(bus.a_out), 32'(8'h47));
      do_reset();

      // Full entry, held 20 cycles without ready, then one-cycle transfer
      press(8'h25);
      press(8'hF3);
      e = '{a: 8'h25, b: 8'hF3, op: 3'b010};
      sb_q.push_back(e);
      press(8'h02);
      sw_in = 8'hA5;
      step(20);
      check_outputs("hold20", e, 1'b1, 2'b11);
      check("hold20_pending", 32'(sb_q.size()), 32'(1));
      bus.ready_in = 1'b1;
      step(1);
      bus.ready_in = 1'b0;
      check("after_xfer_valid", 32'(bus.operands_valid), 32'(0));
      check("after_xfer_state", 32'(state_out), 32'(2'b00));
      check("after_xfer_drained", 32'(sb_q.size()), 32'(0));

      // Ready asserted before valid: bundle lives for exactly one cycle
      bus.ready_in = 1'b1;
      press(8'h81);
      press(8'h7F);
      e = '{a: 8'h81, b: 8'h7F, op: 3'b111};
      sb_q.push_back(e);
      press(8'hFF);
      bus.ready_in = 1'b0;
      check("early_ready_drained", 32'(sb_q.size()), 32'(0));
      check("early_ready_state", 32'(state_out), 32'(2'b00));
      check("early_ready_a_kept", 32'(bus.a_out), 32'(8'h81));

      // Clear and next in the same cycle during S_OP
      do_reset();
      press(8'h11);
      press(8'h22);
      check("pre_clear_state", 32'(state_out), 32'(2'b10));
      seen_hold = 1'b0;
      sw_in     = 8'h05;
      btn_next  = 1'b1;
      btn_clear = 1'b1;
      step(DB + 4);
      btn_next  = 1'b0;
      btn_clear = 1'b0;
      step(DB + 4);
      check_outputs("clear_next", '0, 1'b0, 2'b00);
      check("clear_no_hold", 32'(seen_hold), 32'(0));

      // Presses in S_HOLD are ignored
      press(8'h3C);
      press(8'h7E);
      e = '{a: 8'h3C, b: 8'h7E, op: 3'b101};
      sb_q.push_back(e);
      press(8'hC5);
      press(8'h01);
      press(8'h02);
      press(8'h03);
      check_outputs("hold_ignore", e, 1'b1, 2'b11);
      bus.ready_in = 1'b1;
      step(1);
      bus.ready_in = 1'b0;
      check("hold_ignore_drained", 32'(sb_q.size()), 32'(0));

      // Idle behaviour while waiting in S_B
      do_reset();
      press(8'h5A);
      check("idle_entry_state", 32'(state_out), 32'(2'b01));
`ifdef SEQ_TIMEOUT_EN
      step(TO + 10);
      check("timeout_state", 32'(state_out), 32'(2'b00));
      check("timeout_a", 32'(bus.a_out), 32'(0));
`else
      step(200);
      check("no_timeout_state", 32'(state_out), 32'(2'b01));
      check("no_timeout_a", 32'(bus.a_out), 32'(8'h5A));
`endif

      check("final_queue_empty", 32'(sb_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
